// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared types and constants for the mux scan sequencer.
//               SEL_W      - width of the mux select index {s0,s1}
//               SLOT_COUNT - number of mux inputs scanned per pass
//               state_e    - sequencer FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

  localparam int SEL_W      = 2;
  localparam int SLOT_COUNT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mux_scan_sequencer_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : dwell_timer
// Description : Settle-time counter for one select slot. Counts up while en
//               is high; clear has priority and returns the count to zero.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset
//               clear   - synchronous clear of the count
//               en      - advance the count by one
//               expired - count has reached DWELL-1 (last settle cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [DWELL_W-1:0] LAST_CNT = DWELL_W'(DWELL - 1);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sequencer
// Description : Steps a 4:1 mux through inputs i0..i3, waits DWELL cycles on
//               each select, samples the mux output d into a 4-bit word and
//               strobes valid for one cycle. Single-pass or continuous, with
//               abort.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               start  - request a scan (accepted only when idle)
//               mode   - 0 single pass, 1 continuous (latched on start)
//               abort  - terminate any scan, back to idle
//               d      - mux output
//               s0/s1  - mux select, index = {s0,s1}
//               sample - result word, bit k = d captured with index k
//               valid  - one-cycle strobe, sample updated this cycle
//               busy   - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  abort,
  input  logic                  d,
  output logic                  s0,
  output logic                  s1,
  output logic [SLOT_COUNT-1:0] sample,
  output logic                  valid,
  output logic                  busy
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(SLOT_COUNT - 1);

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  mode_q, mode_d;
  logic [SLOT_COUNT-1:0] shadow_q, shadow_d;
  logic [SLOT_COUNT-1:0] sample_q, sample_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  // The counter only runs in SETTLE; it is held at zero everywhere else so
  // every slot starts its settle window from a clean count.
  assign timer_en    = (state_q == SETTLE);
  assign timer_clear = (state_q != SETTLE) || timer_expired || abort;

  dwell_timer #(
    .DWELL   (DWELL),
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic (abort overrides every transition)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = SETTLE;
        SETTLE:  if (timer_expired) state_d = CAPTURE;
        CAPTURE: state_d = (idx_q == LAST_IDX) ? DONE : SETTLE;
        DONE:    state_d = mode_q ? SETTLE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    valid = (state_q == DONE);
    busy  = (state_q != IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    idx_d    = idx_q;
    mode_d   = mode_q;
    shadow_d = shadow_q;
    sample_d = sample_q;

    if (abort) begin
      idx_d    = '0;
      shadow_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx_d  = '0;
            mode_d = mode;
          end
        end
        CAPTURE: begin
          shadow_d[idx_q] = d;
          if (idx_q == LAST_IDX) begin
            // Publish on the edge entering DONE, including the bit being
            // captured on this same edge.
            sample_d = shadow_d;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end
        DONE: begin
          idx_d = '0;
        end
        default: ;
      endcase
    end

    // Select is registered from the next state so it changes together with
    // the state and never glitches; it parks at 00 in IDLE and DONE.
    sel_d = ((state_d == SETTLE) || (state_d == CAPTURE)) ? idx_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      sel_q    <= '0;
      mode_q   <= 1'b0;
      shadow_q <= '0;
      sample_q <= '0;
    end else begin
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
    end
  end

  assign s0     = sel_q[1];
  assign s1     = sel_q[0];
  assign sample = sample_q;

endmodule
`default_nettype wire
